// File: rtl/inp_button_pio.sv
// inp_button_pio: debounced multi-channel input PIO with configurable edge capture,
// maskable level IRQ and an Avalon-MM slave with registered read data.
module inp_button_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int BIT_CLEAR       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1, s2, db, db_d, ev, clr, edge_capture, irq_mask;
    logic wr;

    assign wr = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '0;
            s2   <= '0;
            db_d <= '0;
        end else begin
            s1   <= in_port;
            s2   <= s1;
            db_d <= db;
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          lvl;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (s2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign db[i] = lvl;
    end

    always_comb begin
        ev  = EDGE_TYPE == 0 ? db & ~db_d : EDGE_TYPE == 1 ? ~db & db_d : db ^ db_d;
        clr = (wr && address == 2'd3) ? (BIT_CLEAR != 0 ? writedata : '1) : '0;
    end

    // Set has priority over clear so an edge arriving with the clear write is kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr) | ev;
            if (wr && address == 2'd2) irq_mask <= writedata;
            readdata <= address == 2'd0 ? db :
                        address == 2'd1 ? s2 :
                        address == 2'd2 ? irq_mask : edge_capture;
        end
    end

    assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_inp_button_pio.sv
// tb_inp_button_pio: table-driven check of the default PIO plus edge-type and clear-mode variants.
module tb_inp_button_pio;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [3:0] writedata = 4'd0;
    logic [3:0] in_port = 4'd0;
    logic [3:0] rd0, rd1, rd2;
    logic       irq0, irq1, irq2;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [3:0] in;
        logic       wr;
        logic [1:0] addr;
        logic [3:0] wd;
        int         cyc;
        logic [3:0] rd;
        logic       irq;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    inp_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0), .BIT_CLEAR(1)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0)
    );
    inp_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(1), .BIT_CLEAR(0)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1)
    );
    inp_button_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2), .BIT_CLEAR(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            chipselect = 1'b0;
            write_n    = 1'b1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
    endtask

    initial begin
        // {in_port, write, address, writedata, cycles, expected readdata, expected irq}
        vecs.push_back('{4'b0000, 1'b0, 2'd0, 4'b0000,  2, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd0, 4'b0000, 18, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd0, 4'b0000,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b1, 2'd2, 4'b0001,  1, 4'b0000, 1'b1});
        vecs.push_back('{4'b0001, 1'b0, 2'd2, 4'b0000,  1, 4'b0001, 1'b1});
        vecs.push_back('{4'b0001, 1'b0, 2'd1, 4'b0000,  1, 4'b0001, 1'b1});
        vecs.push_back('{4'b0001, 1'b1, 2'd3, 4'b0001,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  1, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 1'b1, 2'd0, 4'b1111,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b1, 2'd1, 4'b1111,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd2, 4'b0000,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  1, 4'b0000, 1'b0});
        // short pulse on bit 2 is rejected
        vecs.push_back('{4'b0001, 1'b1, 2'd2, 4'b1111,  1, 4'b0001, 1'b0});
        vecs.push_back('{4'b0101, 1'b0, 2'd0, 4'b0000, 10, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd0, 4'b0000, 30, 4'b0001, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  1, 4'b0000, 1'b0});
        // bounce then settle high gives one capture
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000,  3, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  3, 4'b0000, 1'b0});
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000,  3, 4'b0000, 1'b0});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000,  3, 4'b0000, 1'b0});
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000, 30, 4'b0100, 1'b1});
        vecs.push_back('{4'b0101, 1'b1, 2'd3, 4'b0100,  1, 4'b0100, 1'b0});
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000, 30, 4'b0000, 1'b0});
        // per-bit write-1-to-clear
        vecs.push_back('{4'b0000, 1'b0, 2'd3, 4'b0000, 20, 4'b0000, 1'b0});
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000, 22, 4'b0101, 1'b1});
        vecs.push_back('{4'b0101, 1'b1, 2'd3, 4'b0001,  1, 4'b0101, 1'b1});
        vecs.push_back('{4'b0101, 1'b0, 2'd3, 4'b0000,  1, 4'b0100, 1'b1});
        vecs.push_back('{4'b0101, 1'b1, 2'd2, 4'b0001,  1, 4'b1111, 1'b0});
        // bit 3 edge lands on the same edge as its clear write
        vecs.push_back('{4'b1101, 1'b0, 2'd3, 4'b0000, 18, 4'b0100, 1'b0});
        vecs.push_back('{4'b1101, 1'b1, 2'd3, 4'b1000,  1, 4'b0100, 1'b0});
        vecs.push_back('{4'b1101, 1'b0, 2'd3, 4'b0000,  1, 4'b1100, 1'b0});
        // set up for reset in mid-debounce (bit 0 counter at 9)
        vecs.push_back('{4'b1101, 1'b1, 2'd2, 4'b1111,  1, 4'b0001, 1'b1});
        vecs.push_back('{4'b0000, 1'b0, 2'd3, 4'b0000, 20, 4'b1100, 1'b1});
        vecs.push_back('{4'b0001, 1'b0, 2'd3, 4'b0000, 11, 4'b1100, 1'b1});

        #1;
        check("reset_rd", rd0, 4'b0000);
        check("reset_irq", {3'b000, irq0}, 4'b0000);
        step(3);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            in_port    = vecs[i].in;
            address    = vecs[i].addr;
            writedata  = vecs[i].wd;
            chipselect = vecs[i].wr;
            write_n    = ~vecs[i].wr;
            step(vecs[i].cyc);
            check($sformatf("vec%0d_rd", i), rd0, vecs[i].rd);
            check($sformatf("vec%0d_irq", i), {3'b000, irq0}, {3'b000, vecs[i].irq});
        end

        reset_n = 1'b0;
        #2;
        check("midrst_rd", rd0, 4'b0000);
        check("midrst_irq", {3'b000, irq0}, 4'b0000);
        step(1);
        reset_n = 1'b1;
        address = 2'd2;
        step(1);
        check("postrst_mask", rd0, 4'b0000);
        address = 2'd3;
        step(18);
        check("postrst_cap_early", rd0, 4'b0000);
        step(1);
        check("postrst_cap", rd0, 4'b0001);
        check("postrst_irq", {3'b000, irq0}, 4'b0000);

        reset_n = 1'b0;
        in_port = 4'b0000;
        step(1);
        reset_n = 1'b1;
        address = 2'd3;
        in_port = 4'b0010;
        step(25);
        check("fall_only_rise", rd1, 4'b0000);
        check("any_rise", rd2, 4'b0010);
        bus_write(2'd3, 4'b0010);
        address = 2'd3;
        step(1);
        check("any_cleared", rd2, 4'b0000);
        check("irq_variants", {2'b00, irq1, irq2}, 4'b0000);
        in_port = 4'b0000;
        step(25);
        check("fall_only_fall", rd1, 4'b0010);
        check("any_fall", rd2, 4'b0010);
        bus_write(2'd3, 4'b0000);
        step(1);
        check("clear_all_write", rd1, 4'b0000);
        check("w1c_zero_write", rd2, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
